wb_uart_tx_arbiter: RTL and testbench

Two-port Wishbone arbiter that shares the single pipelined Wishbone push port of the UART TX block (byte FIFO plus serializer) between two requesters, e.g. the Z80 I/O bridge and a debug/monitor engine. It grants one requester at a time with round-robin fairness, holds the grant for a burst, and limits burst length. It tracks outstanding acks so a grant is only released once every accepted byte has been acknowledged.

---
 rtl/wb_uart_tx_arbiter_if.sv | 44 ++++
 rtl/wb_uart_tx_arbiter.sv | 157 +++++++++++++++
 tb/tb_wb_uart_tx_arbiter.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/wb_uart_tx_arbiter_if.sv
// rtl/wb_uart_tx_arbiter_if.sv - bus bundle between two requesters, the arbiter and the UART TX push port
//
// Purpose: groups the two requester Wishbone ports and the downstream UART TX
// push port. Signal names are given from the arbiter's point of view.
//   i_wbN_cyc/stb/data : requester N cycle, strobe, byte
//   o_wbN_ack/stall    : ack / stall back to requester N
//   o_wb_cyc/stb/data  : shared push port toward the UART TX FIFO
//   i_wb_ack/stall     : ack / stall from the UART TX FIFO
// Modports: slave = arbiter side, master = requester/downstream side.
interface wb_uart_tx_arbiter_if;
  logic       i_wb0_cyc;
  logic       i_wb0_stb;
  logic [7:0] i_wb0_data;
  logic       o_wb0_ack;
  logic       o_wb0_stall;
  logic       i_wb1_cyc;
  logic       i_wb1_stb;
  logic [7:0] i_wb1_data;
  logic       o_wb1_ack;
  logic       o_wb1_stall;
  logic       o_wb_cyc;
  logic       o_wb_stb;
  logic [7:0] o_wb_data;
  logic       i_wb_ack;
  logic       i_wb_stall;

  modport slave (
    input  i_wb0_cyc, i_wb0_stb, i_wb0_data,
    output o_wb0_ack, o_wb0_stall,
    input  i_wb1_cyc, i_wb1_stb, i_wb1_data,
    output o_wb1_ack, o_wb1_stall,
    output o_wb_cyc, o_wb_stb, o_wb_data,
    input  i_wb_ack, i_wb_stall
  );

  modport master (
    output i_wb0_cyc, i_wb0_stb, i_wb0_data,
    input  o_wb0_ack, o_wb0_stall,
    output i_wb1_cyc, i_wb1_stb, i_wb1_data,
    input  o_wb1_ack, o_wb1_stall,
    input  o_wb_cyc, o_wb_stb, o_wb_data,
    output i_wb_ack, i_wb_stall
  );
endinterface

// File: rtl/wb_uart_tx_arbiter.sv
// rtl/wb_uart_tx_arbiter.sv - round-robin two-port Wishbone arbiter for the UART TX push port
//
// Purpose: shares the UART TX byte push port between two requesters. One owner
// at a time, round-robin on ties, bursts capped at MAX_BURST, and the grant is
// only released once every accepted byte has been acknowledged.
// Ports:
//   i_clk, i_reset : clock, synchronous active-high reset
//   bus            : wb_uart_tx_arbiter_if.slave (both requesters + downstream)
//   o_grant        : one-hot current owner, 00 = none
// Optional: define UART_TX_ARB_TIMEOUT_EN to release an owner that holds cyc
// without strobing for TIMEOUT_CYCLES cycles.
module wb_uart_tx_arbiter #(
  parameter int MAX_BURST      = 16,
  parameter int CNT_W          = 5,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  wb_uart_tx_arbiter_if.slave   bus,
  output logic [1:0]            o_grant
);

  if (MAX_BURST < 1 || MAX_BURST > (2 ** CNT_W) - 1 || TIMEOUT_CYCLES < 1) begin : g_bad_params
    $error("wb_uart_tx_arbiter: illegal parameter set");
  end

  typedef enum logic [1:0] {S_IDLE, S_GRANT, S_DRAIN} state_t;

  localparam logic [CNT_W-1:0] MAX_B   = CNT_W'(MAX_BURST);
  localparam logic [CNT_W-1:0] CNT_TOP = '1;

  state_t           state_q, state_d;
  logic [1:0]       grant_q, grant_d;
  logic [CNT_W-1:0] burst_q, burst_d;
  logic [CNT_W-1:0] outst_q, outst_d;
  logic             last_q, last_d;

`ifdef UART_TX_ARB_TIMEOUT_EN
  localparam int           TO_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
  logic [TO_W-1:0] idle_q, idle_d;
`endif

  logic       owner;
  logic       req_cyc, req_stb;
  logic [7:0] req_data;
  logic       limit;
  logic       ack_ok;
  logic       accept;
  logic       wb_cyc, wb_stb;
  logic [7:0] wb_data;
  logic       stall0, stall1;

  assign owner    = grant_q[1];
  assign req_cyc  = owner ? bus.i_wb1_cyc  : bus.i_wb0_cyc;
  assign req_stb  = owner ? bus.i_wb1_stb  : bus.i_wb0_stb;
  assign req_data = owner ? bus.i_wb1_data : bus.i_wb0_data;
  assign limit    = (burst_q == MAX_B);
  // An ack with nothing outstanding is a downstream protocol error: swallow it.
  assign ack_ok   = bus.i_wb_ack && (outst_q != '0) && !i_reset;

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    burst_d = burst_q;
    outst_d = outst_q;
    last_d  = last_q;
    wb_cyc  = 1'b0;
    wb_stb  = 1'b0;
    wb_data = 8'h00;
    stall0  = 1'b1;
    stall1  = 1'b1;
    accept  = 1'b0;
`ifdef UART_TX_ARB_TIMEOUT_EN
    idle_d  = '0;
`endif

    unique case (state_q)
      S_IDLE: begin
        burst_d = '0;
        // Tie goes to the port that did not own last time.
        if (bus.i_wb0_cyc && (!bus.i_wb1_cyc || last_q)) begin
          grant_d = 2'b01;
          state_d = S_GRANT;
        end else if (bus.i_wb1_cyc) begin
          grant_d = 2'b10;
          state_d = S_GRANT;
        end
      end
      S_GRANT: begin
        wb_cyc  = 1'b1;
        wb_data = req_data;
        wb_stb  = req_cyc && req_stb && !limit;
        if (owner) stall1 = bus.i_wb_stall || limit;
        else       stall0 = bus.i_wb_stall || limit;
        accept = wb_stb && !bus.i_wb_stall;
        if (accept && burst_q != CNT_TOP) burst_d = burst_q + 1'b1;
        if (!req_cyc || limit) state_d = S_DRAIN;
`ifdef UART_TX_ARB_TIMEOUT_EN
        if (req_cyc && !req_stb) begin
          if (idle_q == TO_LAST) state_d = S_DRAIN;
          else                   idle_d  = idle_q + 1'b1;
        end
`endif
      end
      S_DRAIN: begin
        wb_cyc = 1'b1;
        if (outst_q == '0) begin
          state_d = S_IDLE;
          last_d  = owner;
          grant_d = 2'b00;
          burst_d = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    unique case ({accept, ack_ok})
      2'b10:   if (outst_q != CNT_TOP) outst_d = outst_q + 1'b1;
      2'b01:   outst_d = outst_q - 1'b1;
      default: outst_d = outst_q;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= S_IDLE;
      grant_q <= 2'b00;
      burst_q <= '0;
      outst_q <= '0;
      last_q  <= 1'b1;
`ifdef UART_TX_ARB_TIMEOUT_EN
      idle_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      burst_q <= burst_d;
      outst_q <= outst_d;
      last_q  <= last_d;
`ifdef UART_TX_ARB_TIMEOUT_EN
      idle_q  <= idle_d;
`endif
    end
  end

  // Reset overrides the bus immediately, not only from the next edge.
  assign bus.o_wb_cyc    = wb_cyc && !i_reset;
  assign bus.o_wb_stb    = wb_stb && !i_reset;
  assign bus.o_wb_data   = wb_data;
  assign bus.o_wb0_stall = stall0 || i_reset;
  assign bus.o_wb1_stall = stall1 || i_reset;
  assign bus.o_wb0_ack   = ack_ok && grant_q[0];
  assign bus.o_wb1_ack   = ack_ok && grant_q[1];
  assign o_grant         = grant_q;

endmodule

// File: tb/tb_wb_uart_tx_arbiter.sv
// tb/tb_wb_uart_tx_arbiter.sv - scoreboard bench for wb_uart_tx_arbiter
module tb_wb_uart_tx_arbiter;
  localparam int MB = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] grant;

  always #5 clk = ~clk;

  wb_uart_tx_arbiter_if bus();

  wb_uart_tx_arbiter #(.MAX_BURST(MB), .CNT_W(5), .TIMEOUT_CYCLES(16)) u_dut (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (bus),
    .o_grant (grant)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  logic [7:0] src0[$];
  logic [7:0] src1[$];
  logic [7:0] exp_q[$];
  bit hold0 = 0, hold1 = 0;
  bit acc0 = 0, acc1 = 0;
  bit pend = 0;
  bit ack_en = 1, ack_force = 0;
  int n_acc = 0, n_ack0 = 0, n_ack1 = 0;

  // Requester models: present queue head, advance after an accepted beat.
  always @(posedge clk) begin
    #1;
    if (acc0 && src0.size() > 0) void'(src0.pop_front());
    if (acc1 && src1.size() > 0) void'(src1.pop_front());
    bus.i_wb0_cyc  = hold0 || (src0.size() > 0);
    bus.i_wb0_stb  = src0.size() > 0;
    bus.i_wb0_data = (src0.size() > 0) ? src0[0] : 8'h00;
    bus.i_wb1_cyc  = hold1 || (src1.size() > 0);
    bus.i_wb1_stb  = src1.size() > 0;
    bus.i_wb1_data = (src1.size() > 0) ? src1[0] : 8'h00;
    // Downstream FIFO acks one cycle after it accepts.
    bus.i_wb_ack   = (ack_en && pend) || ack_force;
  end

  // Monitor and scoreboard, sampled mid-cycle.
  always @(negedge clk) begin
    acc0 = bus.i_wb0_cyc && bus.i_wb0_stb && !bus.o_wb0_stall;
    acc1 = bus.i_wb1_cyc && bus.i_wb1_stb && !bus.o_wb1_stall;
    pend = bus.o_wb_stb && !bus.i_wb_stall;
    if (pend) begin
      n_acc++;
      if (exp_q.size() == 0) check_eq("extra_beat", {24'h0, bus.o_wb_data}, 32'h100);
      else                   check_eq("wb_data", {24'h0, bus.o_wb_data}, {24'h0, exp_q.pop_front()});
    end
    if (bus.o_wb0_ack) n_ack0++;
    if (bus.o_wb1_ack) n_ack1++;
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    src0.delete(); src1.delete();
    hold0 = 0; hold1 = 0;
    ack_en = 1; ack_force = 0;
    bus.i_wb_stall = 1'b0;
    tick(); tick();
    rst = 1'b0;
    exp_q.delete();
    n_acc = 0; n_ack0 = 0; n_ack1 = 0;
  endtask

  task automatic wait_grant(input string tag, input logic [1:0] exp);
    int k = 0;
    while (grant !== exp && k < 200) begin tick(); k++; end
    check_eq(tag, {30'h0, grant}, {30'h0, exp});
  endtask

  task automatic wait_done(input string tag);
    int k = 0;
    while (!(src0.size() == 0 && src1.size() == 0 && grant == 2'b00) && k < 400) begin tick(); k++; end
    check_eq(tag, exp_q.size(), 0);
  endtask

  task automatic wait_acc(input int n);
    int k = 0;
    while (n_acc < n && k < 200) begin tick(); k++; end
    check_eq("acc_reached", n_acc, n);
  endtask

  initial begin
    bus.i_wb_stall = 1'b0;
    tick();
    // Reset state
    check_eq("rst_grant", {30'h0, grant}, 0);
    check_eq("rst_cyc", bus.o_wb_cyc, 0);
    check_eq("rst_stb", bus.o_wb_stb, 0);
    check_eq("rst_stall0", bus.o_wb0_stall, 1);
    check_eq("rst_stall1", bus.o_wb1_stall, 1);
    check_eq("rst_ack", {bus.o_wb0_ack, bus.o_wb1_ack}, 0);

    // 1: single requester, three bytes
    do_reset();
    for (int i = 0; i < 3; i++) begin src0.push_back(8'h41 + 8'(i)); exp_q.push_back(8'h41 + 8'(i)); end
    tick();
    check_eq("t1_lat_idle", {30'h0, grant}, 0);
    tick();
    check_eq("t1_grant", {30'h0, grant}, 2'b01);
    wait_done("t1_sb_empty");
    check_eq("t1_ack0", n_ack0, 3);
    check_eq("t1_ack1", n_ack1, 0);

    // 2: tie after reset, then alternation
    do_reset();
    src0.push_back(8'hA0); src0.push_back(8'hA1);
    src1.push_back(8'hB0); src1.push_back(8'hB1);
    exp_q.push_back(8'hA0); exp_q.push_back(8'hA1);
    exp_q.push_back(8'hB0); exp_q.push_back(8'hB1);
    wait_grant("t2_first_p0", 2'b01);
    wait_grant("t2_then_p1", 2'b10);
    wait_grant("t2_release", 2'b00);
    src0.push_back(8'hC0); src1.push_back(8'hD0);
    exp_q.push_back(8'hC0); exp_q.push_back(8'hD0);
    wait_grant("t2_tie2_p0", 2'b01);
    wait_grant("t2_tie2_p1", 2'b10);
    wait_done("t2_sb_empty");
    check_eq("t2_ack0", n_ack0, 3);
    check_eq("t2_ack1", n_ack1, 3);

    // 3: burst limit with the other port waiting
    do_reset();
    for (int i = 0; i < 10; i++) src0.push_back(8'h10 + 8'(i));
    for (int i = 0; i < 3; i++)  src1.push_back(8'h20 + 8'(i));
    for (int i = 0; i < 4; i++)  exp_q.push_back(8'h10 + 8'(i));
    for (int i = 0; i < 3; i++)  exp_q.push_back(8'h20 + 8'(i));
    for (int i = 4; i < 10; i++) exp_q.push_back(8'h10 + 8'(i));
    wait_grant("t3_p0", 2'b01);
    wait_acc(4);
    tick();
    check_eq("t3_limit_stall0", bus.o_wb0_stall, 1);
    check_eq("t3_limit_stb", bus.o_wb_stb, 0);
    check_eq("t3_limit_grant", {30'h0, grant}, 2'b01);
    wait_grant("t3_p1", 2'b10);
    wait_grant("t3_p0_resume", 2'b01);
    wait_done("t3_sb_empty");
    check_eq("t3_ack0", n_ack0, 10);
    check_eq("t3_ack1", n_ack1, 3);

    // 4: downstream stall mid-burst
    do_reset();
    src0.push_back(8'h54); src0.push_back(8'h55); src0.push_back(8'h56);
    exp_q.push_back(8'h54); exp_q.push_back(8'h55); exp_q.push_back(8'h56);
    wait_acc(1);
    @(posedge clk); #2;
    bus.i_wb_stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_eq("t4_stall0", bus.o_wb0_stall, 1);
    end
    check_eq("t4_no_accept", n_acc, 1);
    @(posedge clk); #2;
    bus.i_wb_stall = 1'b0;
    wait_done("t4_sb_empty");
    check_eq("t4_accepts", n_acc, 3);
    check_eq("t4_ack0", n_ack0, 3);

    // 5: reset with two acks outstanding
    do_reset();
    ack_en = 0;
    hold0 = 1;
    src0.push_back(8'h61); src0.push_back(8'h62);
    exp_q.push_back(8'h61); exp_q.push_back(8'h62);
    wait_acc(2);
    tick();
    rst = 1'b1;
    hold0 = 0;
    #1;
    check_eq("t5_in_rst_cyc", bus.o_wb_cyc, 0);
    check_eq("t5_in_rst_stall0", bus.o_wb0_stall, 1);
    tick();
    rst = 1'b0;
    check_eq("t5_grant", {30'h0, grant}, 0);
    check_eq("t5_cyc", bus.o_wb_cyc, 0);
    check_eq("t5_stalls", {bus.o_wb0_stall, bus.o_wb1_stall}, 2'b11);
    n_ack0 = 0; n_ack1 = 0;
    for (int i = 0; i < 2; i++) begin
      ack_force = 1; tick();
      ack_force = 0; tick();
    end
    check_eq("t5_late_ack", n_ack0 + n_ack1, 0);
    ack_en = 1;

    // 6: owner holds cyc with no strobe
    do_reset();
    hold0 = 1;
    src1.push_back(8'h71);
    exp_q.push_back(8'h71);
    wait_grant("t6_p0", 2'b01);
`ifdef UART_TX_ARB_TIMEOUT_EN
    begin
      int k = 0;
      while (grant !== 2'b10 && k < 60) begin tick(); k++; end
      check_eq("t6_timeout_cycles", k, 18);
    end
    hold0 = 0;
    wait_done("t6_sb_empty");
`else
    begin
      bit seen_p1 = 0;
      for (int i = 0; i < 40; i++) begin
        tick();
        if (grant[1]) seen_p1 = 1;
      end
      check_eq("t6_no_p1", seen_p1, 0);
    end
    hold0 = 0;
    wait_grant("t6_p1_after_release", 2'b10);
    wait_done("t6_sb_empty");
`endif
    check_eq("t6_ack1", n_ack1, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
